// File: rtl/srl_mux_fifo.sv
// First-word-fall-through FIFO: SRL32-style shift-register storage, a select tree
// driven by the read index, and a registered output stage.
module srl_mux_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [WIDTH-1:0]      DIN,
    output logic                  FULL,
    input  logic                  RD_EN,
    output logic [WIDTH-1:0]      DOUT,
    output logic                  DOUT_VLD,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NGRP  = DEPTH / 32;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_srl [DEPTH];
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_vld;
    logic [WIDTH-1:0]      r_dout;
    logic                  r_full;
    logic [CNT_W-1:0]      r_level;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_push;
    logic                  w_load;
    logic [DEPTH_LOG2-1:0] w_ra;
    logic [WIDTH-1:0]      w_node [2*NGRP-1];
    logic [WIDTH-1:0]      w_mux;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_vld_nxt;
    logic [WIDTH-1:0]      w_dout_nxt;
    logic [CNT_W-1:0]      w_level_nxt;
    logic                  w_full_nxt;

    assign w_push = WR_EN & ~r_full;
    assign w_load = (r_cnt != {CNT_W{1'b0}}) & (~r_vld | RD_EN);
    // cnt == DEPTH has zero low bits, so the wrap yields DEPTH-1 as required
    assign w_ra   = r_cnt[DEPTH_LOG2-1:0] - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // Heap-ordered select tree: leaves are SRL32 taps, root is the deepest MUXF stage.
    // An internal node at depth d selects with ra[DEPTH_LOG2-1-d].
    genvar g, k;
    generate
        for (g = 0; g < NGRP; g++) begin : g_tap
            localparam logic [DEPTH_LOG2-1:0] GB = DEPTH_LOG2'(g * 32);
            assign w_node[NGRP-1+g] = r_srl[GB | DEPTH_LOG2'(w_ra[4:0])];
        end
        for (k = 0; k < NGRP - 1; k++) begin : g_mux
            localparam int D = $clog2(k + 2) - 1;
            assign w_node[k] = w_ra[DEPTH_LOG2-1-D] ? w_node[2*k+2] : w_node[2*k+1];
        end
    endgenerate

    assign w_mux = w_node[0];

    // Next-state for count, output register and derived status
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_vld_nxt  = r_vld;
        w_dout_nxt = r_dout;
        if (w_load) begin
            w_dout_nxt = w_mux;
            w_vld_nxt  = 1'b1;
        end else if (RD_EN && r_vld) begin
            w_vld_nxt  = 1'b0;
        end else begin
            w_vld_nxt  = r_vld;
        end
        if (w_push && !w_load) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!w_push && w_load) begin
            w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
        w_level_nxt = w_cnt_nxt + {{(CNT_W-1){1'b0}}, w_vld_nxt};
        w_full_nxt  = (w_cnt_nxt == CNT_W'(DEPTH));
    end

    // SRL storage shifts on push and is never cleared, like the primitive
    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_srl[0] <= DIN;
            for (int i = 1; i < DEPTH; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_vld   <= 1'b0;
            r_dout  <= {WIDTH{1'b0}};
            r_full  <= 1'b0;
            r_level <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
            r_dout  <= w_dout_nxt;
            r_full  <= w_full_nxt;
            r_level <= w_level_nxt;
            r_ovf   <= WR_EN & r_full;
            r_udf   <= RD_EN & ~r_vld;
        end
    end

    assign FULL      = r_full;
    assign DOUT      = r_dout;
    assign DOUT_VLD  = r_vld;
    assign LEVEL     = r_level;
    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_udf;

endmodule

// File: tb/tb_srl_mux_fifo.sv
// Directed bench for srl_mux_fifo (WIDTH=16, DEPTH_LOG2=8) with hand-derived expectations.
module tb_srl_mux_fifo;

    localparam int W  = 16;
    localparam int DL = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          WR_EN = 1'b0;
    logic [W-1:0]  DIN = '0;
    logic          FULL;
    logic          RD_EN = 1'b0;
    logic [W-1:0]  DOUT;
    logic          DOUT_VLD;
    logic [DL:0]   LEVEL;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    int n_checks = 0;
    int n_errors = 0;

    srl_mux_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .FULL(FULL),
        .RD_EN(RD_EN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .LEVEL(LEVEL),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            WR_EN = 1'b1;
            DIN   = W'(base + i);
            tick();
        end
        WR_EN = 1'b0;
    endtask

    task automatic drain(input int n, input int base, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_vld"}, 32'(DOUT_VLD), 32'd1);
            check({tag, "_dout"}, 32'(DOUT), 32'(W'(base + i)));
            RD_EN = 1'b1;
            tick();
            if (i == 0) check({tag, "_full_clr"}, 32'(FULL), 32'd0);
        end
        RD_EN = 1'b0;
        check({tag, "_empty_vld"}, 32'(DOUT_VLD), 32'd0);
        check({tag, "_empty_level"}, 32'(LEVEL), 32'd0);
        check({tag, "_no_udf"}, 32'(UNDERFLOW), 32'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_vld", 32'(DOUT_VLD), 32'd0);
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_flags", {30'd0, OVERFLOW, UNDERFLOW}, 32'd0);

        // three pushes, first-word latency, then three pops
        WR_EN = 1'b1; DIN = 16'h0011; tick();
        check("t1_vld_e0", 32'(DOUT_VLD), 32'd0);
        check("t1_lvl_e0", 32'(LEVEL), 32'd1);
        DIN = 16'h0022; tick();
        check("t1_vld_e1", 32'(DOUT_VLD), 32'd1);
        check("t1_dout_e1", 32'(DOUT), 32'h11);
        DIN = 16'h0033; tick();
        WR_EN = 1'b0;
        check("t1_lvl3", 32'(LEVEL), 32'd3);
        check("t1_dout_hold", 32'(DOUT), 32'h11);
        RD_EN = 1'b1; tick();
        check("t1_pop1", 32'(DOUT), 32'h22);
        check("t1_pop1_lvl", 32'(LEVEL), 32'd2);
        tick();
        check("t1_pop2", 32'(DOUT), 32'h33);
        tick();
        RD_EN = 1'b0;
        check("t1_pop3_vld", 32'(DOUT_VLD), 32'd0);
        check("t1_pop3_lvl", 32'(LEVEL), 32'd0);
        check("t1_pop3_hold", 32'(DOUT), 32'h33);

        // fill to capacity, overflow, drain in order
        do_reset();
        fill(257, 0);
        check("t2_level", 32'(LEVEL), 32'd257);
        check("t2_full", 32'(FULL), 32'd1);
        check("t2_ovf_idle", 32'(OVERFLOW), 32'd0);
        WR_EN = 1'b1; DIN = 16'h00AA; tick();
        WR_EN = 1'b0;
        check("t2_ovf", 32'(OVERFLOW), 32'd1);
        check("t2_ovf_level", 32'(LEVEL), 32'd257);
        tick();
        check("t2_ovf_pulse", 32'(OVERFLOW), 32'd0);
        drain(257, 0, "t2");

        // 200 words across every select boundary
        do_reset();
        fill(200, 16'h1000);
        check("t3_level", 32'(LEVEL), 32'd200);
        check("t3_full", 32'(FULL), 32'd0);
        drain(200, 16'h1000, "t3");

        // streaming: DOUT primed, then push and pop every cycle
        do_reset();
        WR_EN = 1'b1; DIN = 16'd3; tick();
        DIN = 16'd10; tick();
        check("t4_prime_dout", 32'(DOUT), 32'd3);
        check("t4_prime_lvl", 32'(LEVEL), 32'd2);
        RD_EN = 1'b1;
        for (int j = 1; j <= 1000; j++) begin
            DIN = W'((j + 1) * 7 + 3);
            tick();
            check("t4_dout", 32'(DOUT), 32'(W'(j * 7 + 3)));
            check("t4_stat", {27'd0, DOUT_VLD, FULL, OVERFLOW, UNDERFLOW, 1'b0} | 32'(LEVEL) << 8,
                  32'h210);
        end
        WR_EN = 1'b0; RD_EN = 1'b0;

        // reset while holding 5 words, with push and pop requested
        do_reset();
        fill(5, 16'h0500);
        check("t5_level5", 32'(LEVEL), 32'd5);
        RST = 1'b1; WR_EN = 1'b1; RD_EN = 1'b1; tick();
        RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
        check("t5_level", 32'(LEVEL), 32'd0);
        check("t5_vld", 32'(DOUT_VLD), 32'd0);
        check("t5_dout", 32'(DOUT), 32'd0);
        check("t5_flags", {30'd0, OVERFLOW, UNDERFLOW}, 32'd0);
        tick();
        check("t5_flags2", {30'd0, OVERFLOW, UNDERFLOW}, 32'd0);
        WR_EN = 1'b1; DIN = 16'h005A; tick();
        WR_EN = 1'b0;
        check("t5_vld_e0", 32'(DOUT_VLD), 32'd0);
        tick();
        check("t5_vld_e1", 32'(DOUT_VLD), 32'd1);
        check("t5_dout_e1", 32'(DOUT), 32'h5A);
        check("t5_lvl_e1", 32'(LEVEL), 32'd1);

        // underflow on empty
        do_reset();
        RD_EN = 1'b1; tick();
        RD_EN = 1'b0;
        check("t6_udf", 32'(UNDERFLOW), 32'd1);
        check("t6_level", 32'(LEVEL), 32'd0);
        check("t6_vld", 32'(DOUT_VLD), 32'd0);
        tick();
        check("t6_udf_pulse", 32'(UNDERFLOW), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
